// File: rtl/exe_alu_stage_pkg.sv
// Shared execute-stage definitions: widths, ALUOp codes and FSM states.
package exe_alu_stage_pkg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 8;
    localparam int RADDR_W = 5;
    localparam int SHAMT_W = 5;

    localparam logic RST_ENABLE  = 1'b0;
    localparam logic WRT_ENABLE  = 1'b1;
    localparam logic WRT_DISABLE = 1'b0;

    localparam logic [ALUOP_W-1:0] ALU_ZERO  = 8'h00;
    localparam logic [ALUOP_W-1:0] ALU_ADDI  = 8'h20;
    localparam logic [ALUOP_W-1:0] ALU_ANDI  = 8'h24;
    localparam logic [ALUOP_W-1:0] ALU_ORI   = 8'h25;
    localparam logic [ALUOP_W-1:0] ALU_XORI  = 8'h26;
    localparam logic [ALUOP_W-1:0] ALU_SLTI  = 8'h2a;
    localparam logic [ALUOP_W-1:0] ALU_SLTIU = 8'h2b;
    localparam logic [ALUOP_W-1:0] ALU_SLLI  = 8'h7c;

    typedef enum logic {
        EXE_IDLE  = 1'b0,
        EXE_SHIFT = 1'b1
    } exe_state_e;

endpackage

// File: rtl/exe_alu_stage_serial_shifter.sv
// One-bit-per-cycle left shifter, built only with EXE_SERIAL_SHIFT_EN.
`ifdef EXE_SERIAL_SHIFT_EN
module exe_serial_shifter
    import exe_alu_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [XLEN-1:0]    din,
    output logic               done,
    output logic [XLEN-1:0]    dout
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = 1;

    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]    data_q, data_d;

    // First bit is shifted on the start edge so shamt shifts take shamt cycles.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (start) begin
            data_d = din << 1;
            cnt_d  = shamt - CNT_ONE;
        end else if (cnt_q != '0) begin
            data_d = data_q << 1;
            cnt_d  = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign done = (cnt_q == '0);
    assign dout = data_q;

endmodule
`endif

// File: rtl/exe_alu_stage.sv
// Execute stage: I-type ALU, EXE_MEM output register and shift FSM.
// EXE_SERIAL_SHIFT_EN selects a serial SLLI instead of a barrel shift.
module exe_alu_stage
    import exe_alu_stage_pkg::*;
(
    input  logic               clk_i_EXE,
    input  logic               rst_i_EXE,
    input  logic               valid_i_EXE,
    input  logic [ALUOP_W-1:0] ALUOp_i_EXE,
    input  logic               regWrite_i_EXE,
    input  logic [RADDR_W-1:0] rd_i_EXE,
    input  logic [XLEN-1:0]    rs1_data_i_EXE,
    input  logic [XLEN-1:0]    imm_i_EXE,
    input  logic               stall_i_EXE,
    output logic               busy_o_EXE,
    output logic               valid_o_EXE,
    output logic [XLEN-1:0]    result_o_EXE,
    output logic [RADDR_W-1:0] rd_o_EXE,
    output logic               regWrite_o_EXE
);

    exe_state_e         state_q, state_d;
    logic               valid_q, valid_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic               wr_q, wr_d;

    logic               accept;
    logic               op_ok;
    logic               wr_en;
    logic [XLEN-1:0]    alu_res;
    logic [SHAMT_W-1:0] shamt;
    logic               slt;
    logic               sltu;

    assign shamt      = imm_i_EXE[SHAMT_W-1:0];
    assign slt        = $signed(rs1_data_i_EXE) < $signed(imm_i_EXE);
    assign sltu       = rs1_data_i_EXE < imm_i_EXE;
    assign busy_o_EXE = stall_i_EXE | (state_q != EXE_IDLE);
    assign accept     = valid_i_EXE & ~busy_o_EXE;

    always_comb begin
        alu_res = '0;
        op_ok   = 1'b1;
        unique case (ALUOp_i_EXE)
            ALU_ADDI:  alu_res = rs1_data_i_EXE + imm_i_EXE;
            ALU_ANDI:  alu_res = rs1_data_i_EXE & imm_i_EXE;
            ALU_ORI:   alu_res = rs1_data_i_EXE | imm_i_EXE;
            ALU_XORI:  alu_res = rs1_data_i_EXE ^ imm_i_EXE;
            ALU_SLTI:  alu_res = {{(XLEN-1){1'b0}}, slt};
            ALU_SLTIU: alu_res = {{(XLEN-1){1'b0}}, sltu};
`ifdef EXE_SERIAL_SHIFT_EN
            // Only the shamt==0 case bypasses the serial shifter.
            ALU_SLLI:  alu_res = rs1_data_i_EXE;
`else
            ALU_SLLI:  alu_res = rs1_data_i_EXE << shamt;
`endif
            default:   op_ok   = 1'b0;
        endcase
    end

    assign wr_en = regWrite_i_EXE & op_ok & (rd_i_EXE != '0);

`ifdef EXE_SERIAL_SHIFT_EN
    logic               sh_start;
    logic               sh_done;
    logic [XLEN-1:0]    sh_dout;
    logic [RADDR_W-1:0] prd_q, prd_d;
    logic               pwr_q, pwr_d;

    assign sh_start = accept & (ALUOp_i_EXE == ALU_SLLI) & (shamt != '0);

    exe_serial_shifter u_shifter (
        .clk   (clk_i_EXE),
        .rst   (rst_i_EXE),
        .start (sh_start),
        .shamt (shamt),
        .din   (rs1_data_i_EXE),
        .done  (sh_done),
        .dout  (sh_dout)
    );
`endif

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        result_d = result_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
`ifdef EXE_SERIAL_SHIFT_EN
        prd_d    = prd_q;
        pwr_d    = pwr_q;
`endif
        unique case (state_q)
            EXE_IDLE: begin
`ifdef EXE_SERIAL_SHIFT_EN
                if (sh_start) begin
                    state_d = EXE_SHIFT;
                    valid_d = 1'b0;
                    prd_d   = rd_i_EXE;
                    pwr_d   = wr_en;
                end else
`endif
                if (accept) begin
                    valid_d  = 1'b1;
                    result_d = alu_res;
                    rd_d     = rd_i_EXE;
                    wr_d     = wr_en;
                end else if (!stall_i_EXE) begin
                    valid_d = 1'b0;
                end
            end
            EXE_SHIFT: begin
`ifdef EXE_SERIAL_SHIFT_EN
                // A stall at completion parks here with the count at zero.
                if (!stall_i_EXE) begin
                    if (sh_done) begin
                        state_d  = EXE_IDLE;
                        valid_d  = 1'b1;
                        result_d = sh_dout;
                        rd_d     = prd_q;
                        wr_d     = pwr_q;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
`else
                state_d = EXE_IDLE;
`endif
            end
            default: state_d = EXE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i_EXE) begin
        if (rst_i_EXE == RST_ENABLE) begin
            state_q  <= EXE_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
            wr_q     <= WRT_DISABLE;
`ifdef EXE_SERIAL_SHIFT_EN
            prd_q    <= '0;
            pwr_q    <= WRT_DISABLE;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
`ifdef EXE_SERIAL_SHIFT_EN
            prd_q    <= prd_d;
            pwr_q    <= pwr_d;
`endif
        end
    end

    assign valid_o_EXE    = valid_q;
    assign result_o_EXE   = result_q;
    assign rd_o_EXE       = rd_q;
    assign regWrite_o_EXE = wr_q;

endmodule

// File: tb/tb_exe_alu_stage.sv
// Directed bench for exe_alu_stage with hand-computed expectations.
module tb_exe_alu_stage;
    import exe_alu_stage_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               valid_i;
    logic [ALUOP_W-1:0] op_i;
    logic               wr_i;
    logic [RADDR_W-1:0] rd_i;
    logic [XLEN-1:0]    rs1_i;
    logic [XLEN-1:0]    imm_i;
    logic               stall_i;
    logic               busy_o;
    logic               valid_o;
    logic [XLEN-1:0]    result_o;
    logic [RADDR_W-1:0] rd_o;
    logic               wr_o;

    int n_cmp = 0;
    int n_bad = 0;

    exe_alu_stage dut (
        .clk_i_EXE      (clk),
        .rst_i_EXE      (rst_n),
        .valid_i_EXE    (valid_i),
        .ALUOp_i_EXE    (op_i),
        .regWrite_i_EXE (wr_i),
        .rd_i_EXE       (rd_i),
        .rs1_data_i_EXE (rs1_i),
        .imm_i_EXE      (imm_i),
        .stall_i_EXE    (stall_i),
        .busy_o_EXE     (busy_o),
        .valid_o_EXE    (valid_o),
        .result_o_EXE   (result_o),
        .rd_o_EXE       (rd_o),
        .regWrite_o_EXE (wr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ALUOP_W-1:0] op,
                         input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b,
                         input logic [RADDR_W-1:0] rd,
                         input logic wr);
        op_i    = op;
        rs1_i   = a;
        imm_i   = b;
        rd_i    = rd;
        wr_i    = wr;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [31:0] res,
                           input logic [RADDR_W-1:0] rd,
                           input logic wr);
        chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
        chk({tag, ".result"}, result_o, res);
        chk({tag, ".rd"}, {27'd0, rd_o}, {27'd0, rd});
        chk({tag, ".wr"}, {31'd0, wr_o}, {31'd0, wr});
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy_o && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    int cyc;
    int exp_cyc;

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        op_i    = ALU_ZERO;
        wr_i    = 1'b0;
        rd_i    = '0;
        rs1_i   = '0;
        imm_i   = '0;
        stall_i = 1'b0;
        repeat (2) tick();
        chk_out("reset", 1'b0, 32'h0, 5'd0, 1'b0);
        chk("reset.busy", {31'd0, busy_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        issue(ALU_ADDI, 32'hffff_ffff, 32'h1, 5'd3, 1'b1);
        chk_out("addi_wrap", 1'b1, 32'h0, 5'd3, 1'b1);

        issue(ALU_SLTI, 32'hffff_ffff, 32'h1, 5'd4, 1'b1);
        chk_out("slti", 1'b1, 32'h1, 5'd4, 1'b1);
        issue(ALU_SLTIU, 32'hffff_ffff, 32'h1, 5'd4, 1'b1);
        chk_out("sltiu", 1'b1, 32'h0, 5'd4, 1'b1);

        issue(ALU_ORI, 32'h5, 32'hA, 5'd0, 1'b1);
        chk_out("ori_rd0", 1'b1, 32'hF, 5'd0, 1'b0);

        issue(ALU_XORI, 32'h0000_f0f0, 32'h0000_00ff, 5'd9, 1'b1);
        chk_out("xori", 1'b1, 32'h0000_f00f, 5'd9, 1'b1);
        tick();
        chk_out("bubble", 1'b0, 32'h0000_f00f, 5'd9, 1'b1);

        issue(ALU_ZERO, 32'h1234, 32'h5678, 5'd5, 1'b1);
        chk_out("zeroop", 1'b1, 32'h0, 5'd5, 1'b0);
        issue(8'hff, 32'h1234, 32'h5678, 5'd6, 1'b1);
        chk_out("unknown", 1'b1, 32'h0, 5'd6, 1'b0);
        issue(ALU_ADDI, 32'h10, 32'hffff_fff0, 5'd2, 1'b0);
        chk_out("addi_nowr", 1'b1, 32'h0, 5'd2, 1'b0);

        issue(ALU_ANDI, 32'hff00_ff00, 32'hffff_f0f0, 5'd7, 1'b1);
        chk_out("andi", 1'b1, 32'hff00_f000, 5'd7, 1'b1);
        stall_i = 1'b1;
        op_i    = ALU_ADDI;
        rs1_i   = 32'd10;
        imm_i   = 32'd20;
        rd_i    = 5'd8;
        wr_i    = 1'b1;
        valid_i = 1'b1;
        #1;
        chk("stall.busy0", {31'd0, busy_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall_hold", 1'b1, 32'hff00_f000, 5'd7, 1'b1);
            chk("stall.busy", {31'd0, busy_o}, 32'd1);
        end
        stall_i = 1'b0;
        tick();
        valid_i = 1'b0;
        chk_out("post_stall", 1'b1, 32'd30, 5'd8, 1'b1);

`ifdef EXE_SERIAL_SHIFT_EN
        exp_cyc = 31;
`else
        exp_cyc = 0;
`endif
        issue(ALU_SLLI, 32'h1, 32'h0000_07ff, 5'd10, 1'b1);
        wait_idle(cyc);
        chk("slli31.cycles", cyc, exp_cyc);
        chk_out("slli31", 1'b1, 32'h8000_0000, 5'd10, 1'b1);

        issue(ALU_SLLI, 32'h0f00_0001, 32'h4, 5'd11, 1'b1);
        wait_idle(cyc);
        chk_out("slli4", 1'b1, 32'hf000_0010, 5'd11, 1'b1);

        issue(ALU_SLLI, 32'h1234, 32'h20, 5'd12, 1'b1);
        chk("slli0.busy", {31'd0, busy_o}, 32'd0);
        chk_out("slli0", 1'b1, 32'h1234, 5'd12, 1'b1);

        issue(ALU_SLLI, 32'h3, 32'd20, 5'd13, 1'b1);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        chk_out("rst_mid", 1'b0, 32'h0, 5'd0, 1'b0);
        chk("rst_mid.busy", {31'd0, busy_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk_out("rst_idle", 1'b0, 32'h0, 5'd0, 1'b0);
        issue(ALU_ADDI, 32'd7, 32'hffff_fffe, 5'd14, 1'b1);
        chk_out("addi_after", 1'b1, 32'd5, 5'd14, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
